// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions for the write-back stage.
//   - write-back source select codes (in_wb_sel)
//   - load funct3 codes
//   - default datapath width
//   - load_extend: RV32 load byte/half alignment and sign/zero extension
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Misaligned halves are not trapped: addr_lo[0] is ignored for LH/LHU.
  // Unknown funct3 codes return the full word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file with write-through bypass.
//   clk, rst          : clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata  : single write port (x0 is never written)
//   byp_en, byp_addr,
//   byp_data          : value about to be written; forwarded to matching reads
//   raddr1/2, rdata1/2: two combinational read ports; x0 always reads 0
module regfile_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding keeps decode from reading a stale value while the producing
  // instruction is still sitting in WB (including while it is stalled there).
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      if (byp_en && (raddr1 == byp_addr)) begin
        rdata1 = byp_data;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      if (byp_en && (raddr2 == byp_addr)) begin
        rdata2 = byp_data;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: MEM/WB pipeline register, result select with load
// extension, architectural register file and retired-instruction counter.
//   clk, rst                 : clock, synchronous active-high reset
//   stall, flush             : hold / squash the MEM/WB register (flush wins)
//   in_valid .. in_pc4       : instruction presented by the memory stage
//   rs1_addr/rs2_addr        : decode read addresses
//   rs1_data/rs2_data        : bypassed read data
//   wb_valid, wb_regwrite,
//   wb_rd, wb_data           : registered write-back instruction
//   retired_count            : instructions committed (wraps)
module wb_stage_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREG  = 32,
  parameter int CNT_W = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic [1:0]       in_wb_sel,
  input  logic [AW-1:0]    in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_data,
  input  logic [XLEN-1:0]  in_mem_data,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_valid,
  output logic             wb_regwrite,
  output logic [AW-1:0]    wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] retired_count
);

  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wb_src;
  logic            wb_done;
  logic            commit;
  logic            rf_we;

  // Byte/half extension is only defined for a 32-bit datapath; wider
  // builds pass the raw memory word through.
  if (XLEN == 32) begin : g_load_ext
    assign load_ext = load_extend(in_mem_data, in_funct3, in_addr_lo);
  end else begin : g_load_raw
    assign load_ext = in_mem_data;
  end

  always_comb begin
    wb_src = in_alu_data;
    case (in_wb_sel)
      WB_SEL_MEM: wb_src = load_ext;
      WB_SEL_PC4: wb_src = in_pc4;
      default:    wb_src = in_alu_data;
    endcase
  end

  // wb_done marks that the instruction held in WB has already written and
  // been counted, so a stall does not make it commit on every held edge.
  assign commit = wb_valid & ~wb_done;
  assign rf_we  = commit & wb_regwrite & (wb_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_done       <= 1'b0;
      retired_count <= '0;
    end else begin
      if (flush) begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
      end else if (!stall) begin
        wb_valid    <= in_valid;
        wb_regwrite <= in_regwrite;
        wb_rd       <= in_rd;
        wb_data     <= wb_src;
      end

      if (!flush && !stall) begin
        wb_done <= 1'b0;
      end else if (commit) begin
        wb_done <= 1'b1;
      end

      if (commit) begin
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (wb_rd),
    .wdata    (wb_data),
    .byp_en   (wb_valid & wb_regwrite),
    .byp_addr (wb_rd),
    .byp_data (wb_data),
    .raddr1   (rs1_addr),
    .raddr2   (rs2_addr),
    .rdata1   (rs1_data),
    .rdata2   (rs2_data)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_regwrite;
  logic [1:0]       in_wb_sel;
  logic [AW-1:0]    in_rd;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic [XLEN-1:0]  in_alu_data;
  logic [XLEN-1:0]  in_mem_data;
  logic [XLEN-1:0]  in_pc4;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             wb_valid;
  logic             wb_regwrite;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [CNT_W-1:0] retired_count;

  wb_stage_regfile #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_regwrite   (in_regwrite),
    .in_wb_sel     (in_wb_sel),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_data   (in_alu_data),
    .in_mem_data   (in_mem_data),
    .in_pc4        (in_pc4),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_valid      (wb_valid),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  localparam int NVEC = 16;
  localparam logic [31:0] WORD = 32'h80FF7F01;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  logic [31:0] mdl_reg [NREG];
  int          mdl_count;
  int          checks;
  int          errors;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] sel,
                              input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] exp_data);
    vec_t t;
    t.valid = v; t.regwrite = rw; t.sel = sel; t.rd = rd; t.f3 = f3; t.lo = lo;
    t.alu = alu; t.mem = WORD; t.pc4 = pc4; t.exp_data = exp_data;
    return t;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; in_regwrite = 1'b0; in_wb_sel = 2'b00; in_rd = '0;
    in_funct3 = 3'b010; in_addr_lo = 2'b00;
    in_alu_data = '0; in_mem_data = '0; in_pc4 = '0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    in_valid = v.valid; in_regwrite = v.regwrite; in_wb_sel = v.sel; in_rd = v.rd;
    in_funct3 = v.f3; in_addr_lo = v.lo;
    in_alu_data = v.alu; in_mem_data = v.mem; in_pc4 = v.pc4;
    e.valid = v.valid; e.regwrite = v.regwrite; e.rd = v.rd; e.data = v.exp_data;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expected WB record and compare it, then check bypass on
  // both read ports before the commit edge and retire it into the model.
  task automatic pop_check(input string tag);
    exp_t        e;
    logic [31:0] byp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty queue, expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check32({tag, "_valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
    check32({tag, "_regwrite"}, {31'd0, wb_regwrite}, {31'd0, e.regwrite});
    check32({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    check32({tag, "_data"}, wb_data, e.data);
    check32({tag, "_count"}, retired_count, mdl_count);
    rs1_addr = e.rd;
    rs2_addr = e.rd;
    #1;
    byp = (e.valid && e.regwrite && e.rd != 5'd0) ? e.data : mdl_reg[e.rd];
    check32({tag, "_rs1_byp"}, rs1_data, byp);
    check32({tag, "_rs2_byp"}, rs2_data, byp);
    if (e.valid) begin
      mdl_count++;
      if (e.regwrite && e.rd != 5'd0) mdl_reg[e.rd] = e.data;
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < NREG; a++) begin
      rs1_addr = AW'(a);
      rs2_addr = AW'(NREG - 1 - a);
      #1;
      check32({tag, "_rs1"}, rs1_data, mdl_reg[a]);
      check32({tag, "_rs2"}, rs2_data, mdl_reg[NREG - 1 - a]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    mdl_count = 0;
    for (int a = 0; a < NREG; a++) mdl_reg[a] = '0;

    vecs[0]  = mk(1, 1, 2'b01, 5,  3'b000, 2'd3, 32'h0,   32'h0,   32'hFFFFFF80);
    vecs[1]  = mk(1, 1, 2'b01, 6,  3'b101, 2'd2, 32'h0,   32'h0,   32'h000080FF);
    vecs[2]  = mk(1, 1, 2'b00, 7,  3'b000, 2'd0, 32'h10,  32'h0,   32'h00000010);
    vecs[3]  = mk(1, 1, 2'b10, 8,  3'b000, 2'd0, 32'h0,   32'h104, 32'h00000104);
    vecs[4]  = mk(1, 1, 2'b01, 9,  3'b000, 2'd1, 32'h0,   32'h0,   32'h0000007F);
    vecs[5]  = mk(1, 1, 2'b01, 10, 3'b001, 2'd0, 32'h0,   32'h0,   32'h00007F01);
    vecs[6]  = mk(1, 1, 2'b01, 11, 3'b001, 2'd3, 32'h0,   32'h0,   32'hFFFF80FF);
    vecs[7]  = mk(1, 1, 2'b01, 12, 3'b100, 2'd2, 32'h0,   32'h0,   32'h000000FF);
    vecs[8]  = mk(1, 1, 2'b01, 13, 3'b010, 2'd1, 32'h0,   32'h0,   32'h80FF7F01);
    vecs[9]  = mk(1, 1, 2'b01, 14, 3'b011, 2'd0, 32'h0,   32'h0,   32'h80FF7F01);
    vecs[10] = mk(1, 1, 2'b11, 15, 3'b000, 2'd0, 32'hABC, 32'h200, 32'h00000ABC);
    vecs[11] = mk(1, 1, 2'b00, 0,  3'b000, 2'd0, 32'h55,  32'h0,   32'h00000055);
    vecs[12] = mk(1, 0, 2'b00, 16, 3'b000, 2'd0, 32'h77,  32'h0,   32'h00000077);
    vecs[13] = mk(0, 1, 2'b00, 17, 3'b000, 2'd0, 32'h99,  32'h0,   32'h00000099);
    vecs[14] = mk(1, 1, 2'b01, 5,  3'b000, 2'd0, 32'h0,   32'h0,   32'h00000001);
    vecs[15] = mk(1, 1, 2'b01, 18, 3'b100, 2'd3, 32'h0,   32'h0,   32'h00000080);

    // Reset held with stall and a valid instruction on the inputs.
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    in_valid = 1'b1; in_regwrite = 1'b1; in_wb_sel = 2'b00; in_rd = 5'd3;
    in_funct3 = 3'b010; in_addr_lo = 2'd0;
    in_alu_data = 32'h1111; in_mem_data = 32'h2222; in_pc4 = 32'h3333;
    step();
    step();
    check32("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check32("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    check32("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check32("rst_wb_data", wb_data, 32'd0);
    check32("rst_count", retired_count, 32'd0);
    check_all_regs("rst_reg");
    drive_idle();
    stall = 1'b0;
    rst = 1'b0;
    step();

    // Back-to-back table: each edge loads vector i and commits vector i-1.
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      step();
      pop_check($sformatf("vec%0d", i));
    end
    drive_idle();
    step();
    step();
    check32("tbl_count", retired_count, mdl_count);
    check_all_regs("tbl_reg");

    // Stall for 4 cycles on a valid regwrite instruction.
    apply(mk(1, 1, 2'b00, 21, 3'b000, 2'd0, 32'hCAFE, 32'h0, 32'h0000CAFE));
    step();
    pop_check("stl_load");
    stall = 1'b1;
    in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd22; in_alu_data = 32'hBAD;
    rs1_addr = 5'd21;
    for (int k = 0; k < 4; k++) begin
      step();
      check32("stl_wb_data", wb_data, 32'h0000CAFE);
      check32("stl_wb_rd", {27'd0, wb_rd}, 32'd21);
      check32("stl_wb_valid", {31'd0, wb_valid}, 32'd1);
      check32("stl_count", retired_count, mdl_count);
      check32("stl_rs1_byp", rs1_data, 32'h0000CAFE);
    end
    stall = 1'b0;
    drive_idle();
    step();
    step();
    check32("stl_post_count", retired_count, mdl_count);
    check_all_regs("stl_reg");

    // Flush wins over stall for an incoming valid instruction.
    flush = 1'b1; stall = 1'b1;
    in_valid = 1'b1; in_regwrite = 1'b1; in_wb_sel = 2'b00; in_rd = 5'd23;
    in_alu_data = 32'hF00;
    step();
    check32("fl_wb_valid", {31'd0, wb_valid}, 32'd0);
    check32("fl_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    drive_idle();
    step();
    step();
    check32("fl_count", retired_count, mdl_count);
    check_all_regs("fl_reg");

    // Reset arriving on the commit edge of a stalled instruction.
    apply(mk(1, 1, 2'b00, 20, 3'b000, 2'd0, 32'h1234, 32'h0, 32'h00001234));
    step();
    pop_check("rms_load");
    stall = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b0;
    drive_idle();
    step();
    mdl_count = 0;
    for (int a = 0; a < NREG; a++) mdl_reg[a] = '0;
    check32("rms_count", retired_count, 32'd0);
    check32("rms_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_all_regs("rms_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
